// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - shared framing constants, state encoding and error-flag positions
package uart_cmd_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CMD     = 3'd1,
        LEN     = 3'd2,
        PAYLOAD = 3'd3,
        CHK     = 3'd4,
        HOLD    = 3'd5
    } state_t;

    localparam int ERR_CHECKSUM = 0;
    localparam int ERR_LEN      = 1;
    localparam int ERR_OVERRUN  = 2;
    localparam int ERR_TIMEOUT  = 3;
    localparam int ERR_W        = 4;

endpackage

// File: rtl/uart_cmd_parser_if.sv
// rtl/uart_cmd_parser_if.sv - byte input, command handshake, payload read and error pulses
interface uart_cmd_parser_if #(
    parameter int MAX_PAYLOAD = 16,
    parameter int LEN_W       = 8
);
    localparam int AW = $clog2(MAX_PAYLOAD);

    logic [7:0]       rx_data;
    logic             rx_ready;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [7:0]       cmd_id;
    logic [LEN_W-1:0] cmd_len;
    logic [AW-1:0]    pl_addr;
    logic [7:0]       pl_data;
    logic             err_checksum;
    logic             err_len;
    logic             err_overrun;
    logic             err_timeout;

    // Parser side
    modport slave (
        input  rx_data, rx_ready, cmd_ready, pl_addr,
        output cmd_valid, cmd_id, cmd_len, pl_data,
        output err_checksum, err_len, err_overrun, err_timeout
    );

    // Receiver / command-logic side
    modport master (
        output rx_data, rx_ready, cmd_ready, pl_addr,
        input  cmd_valid, cmd_id, cmd_len, pl_data,
        input  err_checksum, err_len, err_overrun, err_timeout
    );

endinterface

// File: rtl/cmd_payload_buf.sv
// rtl/cmd_payload_buf.sv - payload register file, synchronous write, asynchronous read
module cmd_payload_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem_q [DEPTH];

    // Store one payload byte; contents survive frame aborts
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - sync-hunting command framer; optional inter-byte timeout via UART_CMD_PARSER_TIMEOUT_EN
module uart_cmd_parser #(
    parameter int         MAX_PAYLOAD  = 16,
    parameter int         LEN_W        = 8,
    parameter logic [7:0] SYNC_BYTE    = uart_cmd_pkg::SYNC_BYTE,
    parameter int         TIMEOUT_CLKS = 50000
) (
    input  logic                clk,
    input  logic                rst_n,
    uart_cmd_parser_if.slave    bus
);
    import uart_cmd_pkg::*;

    localparam int         AW      = $clog2(MAX_PAYLOAD);
    localparam logic [8:0] MAX_LEN = 9'(MAX_PAYLOAD);

    // Length byte is 8 bits and the idle counter is 16 bits wide
    if (MAX_PAYLOAD < 2 || MAX_PAYLOAD > 255) begin : g_bad_max_payload
        $error("uart_cmd_parser: MAX_PAYLOAD must be within 2..255");
    end
    if (TIMEOUT_CLKS < 2 || TIMEOUT_CLKS > 65536) begin : g_bad_timeout
        $error("uart_cmd_parser: TIMEOUT_CLKS must be within 2..65536");
    end

    state_t           state_q, state_d;
    logic [7:0]       cmd_id_q, cmd_id_d;
    logic [LEN_W-1:0] cmd_len_q, cmd_len_d;
    logic [7:0]       chk_q, chk_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             buf_we;
    logic             tmo_hit;

`ifdef UART_CMD_PARSER_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CLKS - 1);

    logic [15:0] tmo_q, tmo_d;
    logic        tmo_active;

    assign tmo_active = (state_q == CMD) || (state_q == LEN) ||
                        (state_q == PAYLOAD) || (state_q == CHK);
    assign tmo_hit    = tmo_active && !bus.rx_ready && (tmo_q == TMO_LAST);

    // Idle-gap counter: restarts on every byte, parked at zero outside a frame
    always_comb begin
        tmo_d = '0;
        if (tmo_active && !bus.rx_ready && !tmo_hit) begin
            tmo_d = tmo_q + 16'd1;
        end
    end

    // Idle-gap counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // Frame FSM: next state, field capture, running checksum and error pulses
    always_comb begin
        state_d   = state_q;
        cmd_id_d  = cmd_id_q;
        cmd_len_d = cmd_len_q;
        chk_d     = chk_q;
        idx_d     = idx_q;
        err_d     = '0;
        buf_we    = 1'b0;

        if (tmo_hit) begin
            state_d            = IDLE;
            err_d[ERR_TIMEOUT] = 1'b1;
        end else if (bus.rx_ready) begin
            unique case (state_q)
                IDLE: begin
                    if (bus.rx_data == SYNC_BYTE) begin
                        state_d = CMD;
                        chk_d   = '0;
                    end
                end
                CMD: begin
                    cmd_id_d = bus.rx_data;
                    chk_d    = bus.rx_data;
                    state_d  = LEN;
                end
                LEN: begin
                    if ({1'b0, bus.rx_data} > MAX_LEN) begin
                        err_d[ERR_LEN] = 1'b1;
                        state_d        = IDLE;
                    end else begin
                        chk_d     = chk_q ^ bus.rx_data;
                        cmd_len_d = LEN_W'(bus.rx_data);
                        idx_d     = '0;
                        state_d   = (bus.rx_data == 8'd0) ? CHK : PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    buf_we = 1'b1;
                    chk_d  = chk_q ^ bus.rx_data;
                    idx_d  = idx_q + AW'(1);
                    if (LEN_W'(idx_q) + LEN_W'(1) == cmd_len_q) begin
                        state_d = CHK;
                    end
                end
                CHK: begin
                    if (bus.rx_data == chk_q) begin
                        state_d = HOLD;
                    end else begin
                        err_d[ERR_CHECKSUM] = 1'b1;
                        state_d             = IDLE;
                    end
                end
                HOLD: begin
                    // A byte arriving with the handshake starts the next hunt at once
                    if (bus.cmd_ready) begin
                        if (bus.rx_data == SYNC_BYTE) begin
                            state_d = CMD;
                            chk_d   = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        err_d[ERR_OVERRUN] = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q == HOLD && bus.cmd_ready) begin
            state_d = IDLE;
        end
    end

    // Frame FSM state and captured fields
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cmd_id_q  <= '0;
            cmd_len_q <= '0;
            chk_q     <= '0;
            idx_q     <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            cmd_id_q  <= cmd_id_d;
            cmd_len_q <= cmd_len_d;
            chk_q     <= chk_d;
            idx_q     <= idx_d;
            err_q     <= err_d;
        end
    end

    cmd_payload_buf #(
        .DEPTH (MAX_PAYLOAD),
        .AW    (AW)
    ) u_buf (
        .clk     (clk),
        .we_i    (buf_we),
        .waddr_i (idx_q),
        .wdata_i (bus.rx_data),
        .raddr_i (bus.pl_addr),
        .rdata_o (bus.pl_data)
    );

    assign bus.cmd_valid    = (state_q == HOLD);
    assign bus.cmd_id       = cmd_id_q;
    assign bus.cmd_len      = cmd_len_q;
    assign bus.err_checksum = err_q[ERR_CHECKSUM];
    assign bus.err_len      = err_q[ERR_LEN];
    assign bus.err_overrun  = err_q[ERR_OVERRUN];
    assign bus.err_timeout  = err_q[ERR_TIMEOUT];

endmodule
